mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch requester (IF) and the load/store requester (DM). Uses valid/ready handshakes on both sides and keeps one transaction outstanding at a time. DM has priority over IF, with a bound on how long IF can be starved. The block also rejects misaligned or malformed accesses and converts a memory timeout into an error response. It sits between the CPU core and the memory model, in place of the direct IMEM/DMEM hookup.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_DATA_STREAK, 4, consecutive DM grants allowed while IF is pending
TIMEOUT_CYCLES, 16, cycles in ISSUE+WAIT before the transaction is aborted with an error
TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width

Ports:
SYS_clk  in  1  clock, rising edge
SYS_reset_n  in  1  reset, asynchronous, active-low
if_req_valid  in  1  IF read request
if_req_ready  out  1  IF request accepted this cycle
if_addr  in  ADDR_W  fetch address (word access)
if_resp_valid  out  1  one-cycle IF response pulse
if_rdata  out  DATA_W  fetched word
if_resp_err  out  1  IF error flag, qualified by if_resp_valid
dm_req_valid  in  1  DM request
dm_req_ready  out  1  DM request accepted this cycle
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  byte address
dm_wdata  in  DATA_W  store data
dm_length  in  2  01 = byte, 10 = half, 11 = word, 00 = invalid
dm_signed  in  1  sign-extend load
dm_resp_valid  out  1  one-cycle DM response pulse
dm_rdata  out  DATA_W  load data (0 for stores)
dm_resp_err  out  1  DM error flag, qualified by dm_resp_valid
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_length  out  2  memory access length
mem_signed  out  1  memory sign-extend flag
mem_resp_valid  in  1  memory response (reads and writes)
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clock and reset: one clock, SYS_clk. SYS_reset_n is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0; streak counter and timeout counter 0; request registers 0.
- FSM states and transitions:
  - IDLE: on a request handshake, go to ISSUE, or to RESP if the request is invalid.
  - ISSUE: on mem_req_ready, go to WAIT.
  - WAIT: on mem_resp_valid, go to RESP.
  - RESP: go to IDLE.
- Timeout: in ISSUE or WAIT, when the timeout counter reaches TIMEOUT_CYCLES-1 without progress, go to RESP with err=1.
- Ready signals: x_req_ready = (state==IDLE) & x_req_valid & grant_x, computed combinationally. No requester is accepted in any other state.
- Grant rule:
  - Only DM valid: grant DM. Only IF valid: grant IF.
  - Both valid: grant DM unless streak==MAX_DATA_STREAK, in which case grant IF.
- Streak counter: increments on a DM grant while if_req_valid=1; clears on an IF grant, or on a DM grant with if_req_valid=0; saturates at MAX_DATA_STREAK.
- Request capture: on handshake, latch owner, we, addr, wdata, length and signed. IF requests are latched as we=0, length=11, signed=0.
- Invalid requests skip memory and respond with err=1, rdata=0:
  - IF with addr[1:0]!=0;
  - DM with length 00;
  - half with addr[0]!=0;
  - word with addr[1:0]!=0.
- Memory request outputs: mem_req_valid=1 throughout ISSUE, driven from the latched registers and held stable until mem_req_ready. mem_* outputs are 0 outside ISSUE.
- Response: capture mem_rdata in WAIT on mem_resp_valid. In RESP, pulse the owner's resp_valid for exactly one cycle with err=0. dm_rdata=0 for stores. The non-owner's resp_valid stays 0.
- Timeout counter: clears on entering ISSUE; counts every cycle in ISSUE and WAIT. A timeout in ISSUE drops mem_req_valid without handshake (abort).
- Spurious responses: mem_resp_valid outside WAIT is ignored, including late responses after a timeout.
- Latency, valid access with zero-wait memory: handshake at cycle N, mem_req_valid at N+1, earliest mem_resp_valid at N+2, resp_valid at N+3. Invalid access: resp_valid at N+1.
- Back-to-back: the next request can be accepted in the cycle after RESP (IDLE).
- Reset mid-transaction: the transaction is abandoned immediately; no response is ever produced for it.

Decomposition:
- Shared package mem_arb_pkg:
  - length constants LEN_NONE=00, LEN_BYTE=01, LEN_HALF=10, LEN_WORD=11 (shared with the datapath's MEM_*_length encoding);
  - state enum IDLE/ISSUE/WAIT/RESP;
  - owner encoding OWN_IF/OWN_DM;
  - alignment-check function.
- Sub-module mem_arb_grant: grant logic plus streak counter. Inputs: both valids and a grant-accepted strobe. Outputs: grant_if, grant_dm.

Test Plan:
1. IF only, addr 0x100, memory ready at once, response after 1 cycle with 0xDEADBEEF -> if_req_ready at cycle 0, mem_req_valid at cycle 1, if_resp_valid at cycle 3 with if_rdata=0xDEADBEEF, err=0.
2. Both valid continuously, MAX_DATA_STREAK=4 -> grant order DM, DM, DM, DM, IF, DM…; streak resets after the IF grant.
3. DM store, length 10, addr 0x203 -> no mem_req_valid; dm_resp_valid one cycle after handshake with err=1, dm_rdata=0. Repeat with length 00 at addr 0x200 -> same response.
4. DM load, length 01, signed, addr 0x205, memory returns 0xFFFFFF80 after 5 wait cycles -> mem_length=01, mem_signed=1, mem_addr=0x205 held stable; dm_rdata=0xFFFFFF80.
5. mem_req_ready held 0 for IF addr 0x0, TIMEOUT_CYCLES=16 -> mem_req_valid drops after 16 cycles; if_resp_valid with err=1; a mem_resp_valid pulse 2 cycles later is ignored.
6. Assert SYS_reset_n=0 while in WAIT, release, then drive mem_resp_valid -> all outputs are 0 asynchronously; no resp_valid afterwards; state is IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: length codes,
// FSM states, requester ownership and the access alignment check.
package mem_arb_pkg;

    localparam logic [1:0] LEN_NONE = 2'b00;
    localparam logic [1:0] LEN_BYTE = 2'b01;
    localparam logic [1:0] LEN_HALF = 2'b10;
    localparam logic [1:0] LEN_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // True when an access of this length may legally start at this byte offset.
    function automatic logic req_aligned(input logic [1:0] len, input logic [1:0] addr_lo);
        logic ok;
        case (len)
            LEN_BYTE: ok = 1'b1;
            LEN_HALF: ok = (addr_lo[0] == 1'b0);
            LEN_WORD: ok = (addr_lo == 2'b00);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF, DM and memory-side handshake signals around the arbiter.
// slave = arbiter view, master = core + memory model view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_resp_err;

    logic              dm_req_valid;
    logic              dm_req_ready;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [1:0]        dm_length;
    logic              dm_signed;
    logic              dm_resp_valid;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_resp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_length;
    logic              mem_signed;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_resp_valid, if_rdata, if_resp_err,
        input  dm_req_valid, dm_we, dm_addr, dm_wdata, dm_length, dm_signed,
        output dm_req_ready, dm_resp_valid, dm_rdata, dm_resp_err,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_length, mem_signed,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_resp_valid, if_rdata, if_resp_err,
        output dm_req_valid, dm_we, dm_addr, dm_wdata, dm_length, dm_signed,
        input  dm_req_ready, dm_resp_valid, dm_rdata, dm_resp_err,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_length, mem_signed,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );

endinterface

// File: rtl/mem_arb_grant.sv
// DM-priority grant with a streak counter that forces an IF grant after
// MAX_DATA_STREAK consecutive DM grants taken while IF was waiting.
module mem_arb_grant #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int SW              = $clog2(MAX_DATA_STREAK + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_valid,
    input  logic dm_valid,
    input  logic accept,
    output logic grant_if,
    output logic grant_dm
);

    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    logic [SW-1:0] streak_r;
    logic          starved_s;

    // Grant decode: DM wins unless IF has waited out a full streak.
    always_comb begin
        starved_s = if_valid & (streak_r == STREAK_MAX);
        grant_dm  = dm_valid & ~starved_s;
        grant_if  = if_valid & ~grant_dm;
    end

    // Streak counter, updated only when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_r <= '0;
        end else if (accept) begin
            if (grant_dm && if_valid) begin
                streak_r <= (streak_r == STREAK_MAX) ? streak_r : streak_r + SW'(1);
            end else begin
                streak_r <= '0;
            end
        end else begin
            streak_r <= streak_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// one transaction in flight, with malformed-access rejection and timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int TO_W            = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic               SYS_clk,
    input  logic               SYS_reset_n,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    arb_state_t        state_r;
    owner_t            owner_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [1:0]        len_r;
    logic              signed_r;
    logic [TO_W-1:0]   to_cnt_r;

    logic              mem_req_valid_r;
    logic              if_resp_valid_r;
    logic              if_resp_err_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic              dm_resp_valid_r;
    logic              dm_resp_err_r;
    logic [DATA_W-1:0] dm_rdata_r;

    logic              grant_if_s;
    logic              grant_dm_s;
    logic              if_req_ready_s;
    logic              dm_req_ready_s;
    logic              accept_s;
    logic              timeout_s;

    logic              cap_we_s;
    logic [ADDR_W-1:0] cap_addr_s;
    logic [DATA_W-1:0] cap_wdata_s;
    logic [1:0]        cap_len_s;
    logic              cap_signed_s;
    logic              cap_ok_s;

    logic              fin_s;
    logic              fin_err_s;
    logic              fin_dm_s;
    logic [DATA_W-1:0] fin_data_s;

    mem_arb_grant #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_grant (
        .clk      (SYS_clk),
        .rst_n    (SYS_reset_n),
        .if_valid (bus.if_req_valid),
        .dm_valid (bus.dm_req_valid),
        .accept   (accept_s),
        .grant_if (grant_if_s),
        .grant_dm (grant_dm_s)
    );

    // Handshake decode and selection of the request to be latched.
    always_comb begin
        if_req_ready_s = (state_r == IDLE) & bus.if_req_valid & grant_if_s;
        dm_req_ready_s = (state_r == IDLE) & bus.dm_req_valid & grant_dm_s;
        accept_s       = if_req_ready_s | dm_req_ready_s;
        timeout_s      = (to_cnt_r == TO_LAST);
        if (dm_req_ready_s) begin
            cap_we_s     = bus.dm_we;
            cap_addr_s   = bus.dm_addr;
            cap_wdata_s  = bus.dm_wdata;
            cap_len_s    = bus.dm_length;
            cap_signed_s = bus.dm_signed;
        end else begin
            cap_we_s     = 1'b0;
            cap_addr_s   = bus.if_addr;
            cap_wdata_s  = '0;
            cap_len_s    = LEN_WORD;
            cap_signed_s = 1'b0;
        end
        cap_ok_s = req_aligned(cap_len_s, cap_addr_s[1:0]);
    end

    // Decides when a transaction completes this cycle and with what response.
    always_comb begin
        fin_s      = 1'b0;
        fin_err_s  = 1'b0;
        fin_dm_s   = (owner_r == OWN_DM);
        fin_data_s = '0;
        case (state_r)
            IDLE: begin
                fin_dm_s  = dm_req_ready_s;
                fin_s     = accept_s & ~cap_ok_s;
                fin_err_s = accept_s & ~cap_ok_s;
            end
            ISSUE: begin
                fin_s     = ~bus.mem_req_ready & timeout_s;
                fin_err_s = ~bus.mem_req_ready & timeout_s;
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    fin_s      = 1'b1;
                    fin_data_s = we_r ? '0 : bus.mem_rdata;
                end else begin
                    fin_s     = timeout_s;
                    fin_err_s = timeout_s;
                end
            end
            default: begin
                fin_s = 1'b0;
            end
        endcase
    end

    // Transaction FSM with request registers and registered response outputs.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_r         <= IDLE;
            owner_r         <= OWN_IF;
            we_r            <= 1'b0;
            addr_r          <= '0;
            wdata_r         <= '0;
            len_r           <= LEN_NONE;
            signed_r        <= 1'b0;
            to_cnt_r        <= '0;
            mem_req_valid_r <= 1'b0;
            if_resp_valid_r <= 1'b0;
            if_resp_err_r   <= 1'b0;
            if_rdata_r      <= '0;
            dm_resp_valid_r <= 1'b0;
            dm_resp_err_r   <= 1'b0;
            dm_rdata_r      <= '0;
        end else begin
            // Response registers are set only on the cycle entering RESP.
            if (fin_s) begin
                if_resp_valid_r <= ~fin_dm_s;
                if_resp_err_r   <= ~fin_dm_s & fin_err_s;
                if_rdata_r      <= fin_dm_s ? '0 : fin_data_s;
                dm_resp_valid_r <= fin_dm_s;
                dm_resp_err_r   <= fin_dm_s & fin_err_s;
                dm_rdata_r      <= fin_dm_s ? fin_data_s : '0;
            end else begin
                if_resp_valid_r <= 1'b0;
                if_resp_err_r   <= 1'b0;
                if_rdata_r      <= '0;
                dm_resp_valid_r <= 1'b0;
                dm_resp_err_r   <= 1'b0;
                dm_rdata_r      <= '0;
            end

            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        owner_r  <= dm_req_ready_s ? OWN_DM : OWN_IF;
                        we_r     <= cap_we_s;
                        addr_r   <= cap_addr_s;
                        wdata_r  <= cap_wdata_s;
                        len_r    <= cap_len_s;
                        signed_r <= cap_signed_s;
                        to_cnt_r <= '0;
                        if (cap_ok_s) begin
                            state_r         <= ISSUE;
                            mem_req_valid_r <= 1'b1;
                        end else begin
                            state_r <= RESP;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    to_cnt_r <= to_cnt_r + TO_W'(1);
                    if (bus.mem_req_ready) begin
                        state_r         <= WAIT;
                        mem_req_valid_r <= 1'b0;
                    end else if (timeout_s) begin
                        state_r         <= RESP;
                        mem_req_valid_r <= 1'b0;
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                WAIT: begin
                    to_cnt_r <= to_cnt_r + TO_W'(1);
                    state_r  <= fin_s ? RESP : WAIT;
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r         <= IDLE;
                    mem_req_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_req_ready  = if_req_ready_s;
    assign bus.dm_req_ready  = dm_req_ready_s;
    assign bus.if_resp_valid = if_resp_valid_r;
    assign bus.if_resp_err   = if_resp_err_r;
    assign bus.if_rdata      = if_rdata_r;
    assign bus.dm_resp_valid = dm_resp_valid_r;
    assign bus.dm_resp_err   = dm_resp_err_r;
    assign bus.dm_rdata      = dm_rdata_r;

    // Memory side is driven from the latched request and forced to 0 outside ISSUE.
    assign bus.mem_req_valid = mem_req_valid_r;
    assign bus.mem_we        = mem_req_valid_r & we_r;
    assign bus.mem_addr      = mem_req_valid_r ? addr_r : '0;
    assign bus.mem_wdata     = mem_req_valid_r ? wdata_r : '0;
    assign bus.mem_length    = mem_req_valid_r ? len_r : LEN_NONE;
    assign bus.mem_signed    = mem_req_valid_r & signed_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, grant fairness, malformed
// accesses, wait states, timeout with late response and mid-transaction reset.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic SYS_clk;
    logic SYS_reset_n;
    int   total;
    int   bad;
    logic exp_if;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .SYS_clk     (SYS_clk),
        .SYS_reset_n (SYS_reset_n),
        .bus         (bus)
    );

    initial SYS_clk = 1'b0;
    always #5 SYS_clk = ~SYS_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge SYS_clk);
        @(negedge SYS_clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {22'd0, bus.if_req_ready, bus.if_resp_valid, bus.if_resp_err,
                            bus.dm_req_ready, bus.dm_resp_valid, bus.dm_resp_err,
                            bus.mem_req_valid, bus.mem_we, bus.mem_length, bus.mem_signed}, 32'd0);
        chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
        chk({tag, "_dm_rdata"}, bus.dm_rdata, 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        SYS_reset_n        = 1'b0;
        bus.if_req_valid   = 1'b0;
        bus.if_addr        = 32'd0;
        bus.dm_req_valid   = 1'b0;
        bus.dm_we          = 1'b0;
        bus.dm_addr        = 32'd0;
        bus.dm_wdata       = 32'd0;
        bus.dm_length      = 2'b00;
        bus.dm_signed      = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'd0;

        // Reset state
        @(negedge SYS_clk);
        #1 chk_all_zero("reset");
        @(negedge SYS_clk);
        SYS_reset_n = 1'b1;

        // 1: IF fetch, zero-wait memory
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 32'h0000_0100;
        bus.mem_req_ready = 1'b1;
        #1 chk("t1_if_ready", bus.if_req_ready, 32'd1);
        chk("t1_memv_c0", bus.mem_req_valid, 32'd0);
        tick();
        bus.if_req_valid = 1'b0;
        #1 chk("t1_memv_c1", bus.mem_req_valid, 32'd1);
        chk("t1_mem_addr", bus.mem_addr, 32'h0000_0100);
        chk("t1_mem_len", bus.mem_length, 32'd3);
        chk("t1_mem_we", bus.mem_we, 32'd0);
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hDEAD_BEEF;
        #1 chk("t1_memv_c2", bus.mem_req_valid, 32'd0);
        chk("t1_ifv_c2", bus.if_resp_valid, 32'd0);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'd0;
        #1 chk("t1_ifv_c3", bus.if_resp_valid, 32'd1);
        chk("t1_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
        chk("t1_if_err", bus.if_resp_err, 32'd0);
        chk("t1_dmv_c3", bus.dm_resp_valid, 32'd0);
        tick();
        #1 chk("t1_ifv_c4", bus.if_resp_valid, 32'd0);

        // 2: both requesters always valid -> DM x4, IF, DM x4, IF
        bus.if_req_valid   = 1'b1;
        bus.if_addr        = 32'h0000_0080;
        bus.dm_req_valid   = 1'b1;
        bus.dm_we          = 1'b0;
        bus.dm_addr        = 32'h0000_0040;
        bus.dm_length      = LEN_WORD;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        for (int g = 0; g < 10; g++) begin
            exp_if = (g == 4) || (g == 9);
            #1 chk("t2_if_ready", bus.if_req_ready, {31'd0, exp_if});
            chk("t2_dm_ready", bus.dm_req_ready, {31'd0, ~exp_if});
            tick();
            tick();
            tick();
            #1 chk("t2_if_resp", bus.if_resp_valid, {31'd0, exp_if});
            chk("t2_dm_resp", bus.dm_resp_valid, {31'd0, ~exp_if});
            tick();
        end
        bus.if_req_valid   = 1'b0;
        bus.dm_req_valid   = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        tick();

        // 3: misaligned half store, then invalid length
        bus.dm_req_valid = 1'b1;
        bus.dm_we        = 1'b1;
        bus.dm_length    = LEN_HALF;
        bus.dm_addr      = 32'h0000_0203;
        bus.dm_wdata     = 32'h0000_1234;
        #1 chk("t3a_ready", bus.dm_req_ready, 32'd1);
        tick();
        bus.dm_req_valid = 1'b0;
        #1 chk("t3a_dmv", bus.dm_resp_valid, 32'd1);
        chk("t3a_err", bus.dm_resp_err, 32'd1);
        chk("t3a_rdata", bus.dm_rdata, 32'd0);
        chk("t3a_memv", bus.mem_req_valid, 32'd0);
        chk("t3a_ifv", bus.if_resp_valid, 32'd0);
        tick();
        #1 chk("t3a_dmv_off", bus.dm_resp_valid, 32'd0);
        bus.dm_req_valid = 1'b1;
        bus.dm_length    = LEN_NONE;
        bus.dm_addr      = 32'h0000_0200;
        #1 chk("t3b_ready", bus.dm_req_ready, 32'd1);
        tick();
        bus.dm_req_valid = 1'b0;
        #1 chk("t3b_dmv", bus.dm_resp_valid, 32'd1);
        chk("t3b_err", bus.dm_resp_err, 32'd1);
        chk("t3b_memv", bus.mem_req_valid, 32'd0);
        tick();

        // 4: signed byte load with back-pressure and 5 wait cycles
        bus.dm_req_valid = 1'b1;
        bus.dm_we        = 1'b0;
        bus.dm_length    = LEN_BYTE;
        bus.dm_signed    = 1'b1;
        bus.dm_addr      = 32'h0000_0205;
        #1 chk("t4_ready", bus.dm_req_ready, 32'd1);
        tick();
        bus.dm_req_valid = 1'b0;
        #1 chk("t4_memv", bus.mem_req_valid, 32'd1);
        chk("t4_addr0", bus.mem_addr, 32'h0000_0205);
        chk("t4_len", bus.mem_length, 32'd1);
        chk("t4_signed", bus.mem_signed, 32'd1);
        tick();
        bus.mem_req_ready = 1'b1;
        #1 chk("t4_memv_held", bus.mem_req_valid, 32'd1);
        chk("t4_addr1", bus.mem_addr, 32'h0000_0205);
        tick();
        bus.mem_req_ready = 1'b0;
        for (int w = 0; w < 5; w++) begin
            #1 chk("t4_wait_memv", bus.mem_req_valid, 32'd0);
            chk("t4_wait_dmv", bus.dm_resp_valid, 32'd0);
            tick();
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hFFFF_FF80;
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'd0;
        #1 chk("t4_dmv", bus.dm_resp_valid, 32'd1);
        chk("t4_rdata", bus.dm_rdata, 32'hFFFF_FF80);
        chk("t4_err", bus.dm_resp_err, 32'd0);
        tick();
        bus.dm_signed = 1'b0;

        // 5: memory never ready -> timeout after 16 cycles, late response ignored
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h0000_0000;
        #1 chk("t5_ready", bus.if_req_ready, 32'd1);
        tick();
        bus.if_req_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            #1 chk("t5_memv_hold", bus.mem_req_valid, 32'd1);
            chk("t5_no_resp", bus.if_resp_valid, 32'd0);
            tick();
        end
        #1 chk("t5_memv_drop", bus.mem_req_valid, 32'd0);
        chk("t5_ifv", bus.if_resp_valid, 32'd1);
        chk("t5_err", bus.if_resp_err, 32'd1);
        chk("t5_rdata", bus.if_rdata, 32'd0);
        tick();
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1234_5678;
        tick();
        bus.mem_resp_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1 chk("t5_late_ifv", bus.if_resp_valid, 32'd0);
            chk("t5_late_dmv", bus.dm_resp_valid, 32'd0);
            tick();
        end

        // 6: reset asserted while in WAIT
        bus.dm_req_valid  = 1'b1;
        bus.dm_length     = LEN_WORD;
        bus.dm_addr       = 32'h0000_0300;
        bus.mem_req_ready = 1'b1;
        #1 chk("t6_ready", bus.dm_req_ready, 32'd1);
        tick();
        bus.dm_req_valid = 1'b0;
        tick();
        bus.mem_req_ready = 1'b0;
        #2 SYS_reset_n = 1'b0;
        #1 chk_all_zero("t6_async");
        @(negedge SYS_clk);
        SYS_reset_n        = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h5555_AAAA;
        tick();
        bus.mem_resp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 chk("t6_no_dmv", bus.dm_resp_valid, 32'd0);
            chk("t6_no_ifv", bus.if_resp_valid, 32'd0);
            tick();
        end
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h0000_0004;
        #1 chk("t6_idle", bus.if_req_ready, 32'd1);
        tick();
        bus.if_req_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
